// File: rtl/pulse_handshake_tx_if.sv
// Handshake bundle between the outclk-domain event source and the
// pulse-to-4-phase transmitter.
interface pulse_handshake_tx_if #(
  parameter int PEND_W = 3
);
  logic              event_in;
  logic              ack_async;
  logic              clr_err;
  logic              req;
  logic              busy;
  logic [PEND_W-1:0] pending;
  logic              done;
  logic              overflow;
  logic              timeout_err;

  modport master (
    output event_in, ack_async, clr_err,
    input  req, busy, pending, done, overflow, timeout_err
  );

  modport slave (
    input  event_in, ack_async, clr_err,
    output req, busy, pending, done, overflow, timeout_err
  );
endinterface

// File: rtl/pulse_handshake_tx.sv
// Turns outclk-domain event pulses into 4-phase req/ack transfers,
// queueing events while a transfer is in flight.
module pulse_handshake_tx #(
  parameter int SYNC_STAGES    = 2,
  parameter int PEND_W         = 3,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic                 outclk,
  input logic                 reset,
  pulse_handshake_tx_if.slave bus
);

  localparam logic [PEND_W-1:0] MAX_PEND = '1;
  localparam int TW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TLAST =
    TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    IDLE,
    REQ_HIGH,
    REQ_LOW
  } state_e;

  state_e                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [PEND_W-1:0]      pend_q;
  logic [PEND_W-1:0]      pend_d;
  logic [TW-1:0]          tcnt_q;
  logic                   req_q;
  logic                   done_q;
  logic                   ovf_q;
  logic                   terr_q;

  logic ack_sync;
  logic launch;
  logic inc;
  logic drop;
  logic tmo;

  assign ack_sync = sync_q[SYNC_STAGES-1];
  assign launch   = (state_q == IDLE) && (pend_q != '0)
                    && !ack_sync;
  // A launch on the same edge frees a slot, so no drop then.
  assign inc  = bus.event_in
                && ((pend_q != MAX_PEND) || launch);
  assign drop = bus.event_in && !inc;
  assign tmo  = (TIMEOUT_CYCLES != 0)
                && (state_q == REQ_HIGH)
                && !ack_sync && (tcnt_q == TLAST);

  always_comb begin
    pend_d = pend_q;
    if (inc && !launch) begin
      pend_d = pend_q + 1'b1;
    end else if (!inc && launch) begin
      pend_d = pend_q - 1'b1;
    end
  end

  always_ff @(posedge outclk) begin
    if (reset) begin
      state_q <= IDLE;
      sync_q  <= '0;
      pend_q  <= '0;
      tcnt_q  <= '0;
      req_q   <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.ack_async};
      pend_q <= pend_d;
      done_q <= 1'b0;

      if (drop) begin
        ovf_q <= 1'b1;
      end else if (bus.clr_err) begin
        ovf_q <= 1'b0;
      end

      // A timeout below overrides this clear.
      if (bus.clr_err) begin
        terr_q <= 1'b0;
      end

      unique case (state_q)
        IDLE: begin
          if (launch) begin
            req_q   <= 1'b1;
            tcnt_q  <= '0;
            state_q <= REQ_HIGH;
          end
        end
        REQ_HIGH: begin
          if (ack_sync) begin
            req_q   <= 1'b0;
            state_q <= REQ_LOW;
          end else if (tmo) begin
            req_q   <= 1'b0;
            terr_q  <= 1'b1;
            state_q <= REQ_LOW;
          end else begin
            tcnt_q <= tcnt_q + 1'b1;
          end
        end
        REQ_LOW: begin
          if (!ack_sync) begin
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req         = req_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.pending     = pend_q;
  assign bus.done        = done_q;
  assign bus.overflow    = ovf_q;
  assign bus.timeout_err = terr_q;

endmodule

// File: tb/tb_pulse_handshake_tx.sv
// Self-checking bench for pulse_handshake_tx: vector table, corner
// sequences and a randomized run against a transfer-timeline model.
module tb_pulse_handshake_tx;

  logic outclk = 1'b0;
  logic reset  = 1'b1;

  int n_cmp = 0;
  int n_bad = 0;

  bit fe_en  = 1'b0;
  int fe_cnt = 0;

  pulse_handshake_tx_if #(.PEND_W(3)) bus ();

  pulse_handshake_tx #(
    .SYNC_STAGES    (2),
    .PEND_W         (3),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .outclk (outclk),
    .reset  (reset),
    .bus    (bus)
  );

  always #2 outclk = ~outclk;

  typedef struct {
    logic       ev;
    logic       ack;
    logic       req;
    logic       busy;
    logic [2:0] pend;
    logic       done;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 20)
        $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // Far end: ack follows req after three sampled cycles.
  task automatic far_end();
    if (!fe_en) begin
      fe_cnt = 0;
    end else if (bus.req != bus.ack_async) begin
      fe_cnt++;
      if (fe_cnt == 3) begin
        bus.ack_async = bus.req;
        fe_cnt = 0;
      end
    end else begin
      fe_cnt = 0;
    end
  endtask

  task automatic step();
    @(posedge outclk);
    #1;
    far_end();
  endtask

  task automatic do_reset();
    fe_en = 1'b0;
    fe_cnt = 0;
    bus.event_in  = 1'b0;
    bus.clr_err   = 1'b0;
    bus.ack_async = 1'b0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: sim time expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi, t_at, d_at, n, cnt, rq, dn, fl;
    bit ok, ev, clr, launch, drop;
    int m_pend, m_L, m_next, thr, d;
    bit m_ovf;

    // ---------------- reset state
    do_reset();
    chk("rst_req",  bus.req, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_pend", bus.pending, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_ovf",  bus.overflow, 0);
    chk("rst_terr", bus.timeout_err, 0);

    // ---------------- table: two transfers, manual ack
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 3'd1, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 3'd1, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 3'd1, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b1};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 3'd0, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 3'd0, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0};
    for (int i = 0; i < 16; i++) begin
      bus.event_in  = tbl[i].ev;
      bus.ack_async = tbl[i].ack;
      step();
      chk($sformatf("tbl%0d_req", i),  bus.req,     tbl[i].req);
      chk($sformatf("tbl%0d_busy", i), bus.busy,    tbl[i].busy);
      chk($sformatf("tbl%0d_pend", i), bus.pending, tbl[i].pend);
      chk($sformatf("tbl%0d_done", i), bus.done,    tbl[i].done);
      chk($sformatf("tbl%0d_ovf", i),  bus.overflow, 0);
    end
    bus.event_in = 1'b0;

    // ---------------- saturation, overflow, coincident launch
    do_reset();
    for (int i = 0; i < 8; i++) begin
      bus.event_in = 1'b1;
      step();
    end
    bus.event_in = 1'b0;
    chk("sat8_pend", bus.pending, 7);
    chk("sat8_ovf",  bus.overflow, 0);
    chk("sat8_req",  bus.req, 1);
    bus.event_in = 1'b1;
    step();
    bus.event_in = 1'b0;
    chk("sat9_pend", bus.pending, 7);
    chk("sat9_ovf",  bus.overflow, 1);
    bus.clr_err = 1'b1;
    step();
    bus.clr_err = 1'b0;
    chk("clr_ovf", bus.overflow, 0);
    fe_en = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      step();
      ok = bus.done;
    end
    chk("sat_first_done", ok, 1);
    bus.event_in = 1'b1;
    step();
    bus.event_in = 1'b0;
    chk("coinc_req",  bus.req, 1);
    chk("coinc_pend", bus.pending, 7);
    chk("coinc_ovf",  bus.overflow, 0);
    cnt = 0;
    repeat (110) begin
      step();
      if (bus.done) cnt++;
    end
    chk("drain_done", cnt, 8);
    chk("drain_pend", bus.pending, 0);
    chk("drain_busy", bus.busy, 0);
    chk("drain_terr", bus.timeout_err, 0);

    // ---------------- ack timeout
    do_reset();
    bus.event_in = 1'b1;
    step();
    bus.event_in = 1'b0;
    hi = 0;
    t_at = -1;
    d_at = -1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.req) hi++;
      if (bus.timeout_err && t_at < 0) t_at = i;
      if (bus.done && d_at < 0) d_at = i;
    end
    chk("tmo_req_cycles", hi, 16);
    chk("tmo_err_at", t_at, 16);
    chk("tmo_done_at", d_at, 17);
    chk("tmo_err_sticky", bus.timeout_err, 1);
    bus.clr_err = 1'b1;
    step();
    bus.clr_err = 1'b0;
    chk("tmo_clr", bus.timeout_err, 0);

    // ---------------- reset mid-transfer with ack high
    do_reset();
    for (int i = 0; i < 4; i++) begin
      bus.event_in = 1'b1;
      step();
    end
    bus.event_in = 1'b0;
    chk("mid_pend3", bus.pending, 3);
    chk("mid_req",   bus.req, 1);
    bus.ack_async = 1'b1;
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_rst_req",  bus.req, 0);
    chk("mid_rst_pend", bus.pending, 0);
    chk("mid_rst_busy", bus.busy, 0);
    step();
    step();
    bus.event_in = 1'b1;
    step();
    bus.event_in = 1'b0;
    chk("mid_hold_pend", bus.pending, 1);
    ok = 1'b0;
    repeat (5) begin
      step();
      if (bus.req || bus.busy) ok = 1'b1;
    end
    chk("mid_no_launch", ok, 0);
    bus.ack_async = 1'b0;
    n = 0;
    for (int i = 1; i <= 8 && n == 0; i++) begin
      step();
      if (bus.req) n = i;
    end
    chk("mid_launch_lat", n, 3);

    // ---------------- glitchy ack while idle
    do_reset();
    rq = 0;
    dn = 0;
    fl = 0;
    fork
      begin
        for (int k = 0; k < 28; k++) begin
          #7 bus.ack_async = ~bus.ack_async;
        end
      end
      begin
        for (int k = 0; k < 50; k++) begin
          step();
          if (bus.req) rq++;
          if (bus.done) dn++;
          if (bus.overflow || bus.timeout_err) fl++;
        end
      end
    join
    bus.ack_async = 1'b0;
    chk("glitch_req",   rq, 0);
    chk("glitch_done",  dn, 0);
    chk("glitch_flags", fl, 0);

    // ---------------- random events vs transfer timeline
    // Each transfer occupies 11 edges with this far end:
    // req high for 5, busy for 10, done on the 11th.
    do_reset();
    fe_en = 1'b1;
    m_pend = 0;
    m_L = -1000;
    m_next = 0;
    m_ovf = 1'b0;
    for (int e = 0; e < 900; e++) begin
      thr = ((e / 100) % 2 == 1) ? 45 : 8;
      ev  = (e < 780) && ($urandom_range(0, 99) < thr);
      clr = ($urandom_range(0, 39) == 0);
      bus.event_in = ev;
      bus.clr_err  = clr;
      launch = (m_pend > 0) && (e >= m_next);
      if (launch) begin
        m_L = e;
        m_next = e + 11;
      end
      drop = ev && (m_pend == 7) && !launch;
      if (ev && !drop) m_pend++;
      if (launch) m_pend--;
      m_ovf = drop ? 1'b1 : (clr ? 1'b0 : m_ovf);
      step();
      d = e - m_L;
      chk("rnd_req",  bus.req,  (d >= 0 && d <= 4) ? 1 : 0);
      chk("rnd_busy", bus.busy, (d >= 0 && d <= 9) ? 1 : 0);
      chk("rnd_done", bus.done, (d == 10) ? 1 : 0);
      chk("rnd_pend", bus.pending, m_pend);
      chk("rnd_ovf",  bus.overflow, m_ovf);
      chk("rnd_terr", bus.timeout_err, 0);
    end
    bus.event_in = 1'b0;
    bus.clr_err  = 1'b0;
    chk("rnd_final_pend", bus.pending, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
